// File: rtl/crt_arb_pkg.sv
// Shared types and constants for the CRT point arbiter: FSM states, owner
// encoding and the point record handed to the phosphor display.
package crt_arb_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 10;
  localparam int B_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_TST = 1'b0,
    OWNER_CPU = 1'b1
  } owner_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [B_W-1:0] bright;
  } point_t;

endpackage

// File: rtl/crt_point_arbiter_if.sv
// Point-request handshakes of the two requesters (CPU display path and
// test/overlay generator) feeding the CRT point arbiter.
interface crt_point_arbiter_if;
  import crt_arb_pkg::*;

  logic           cpu_valid;
  logic [X_W-1:0] cpu_x;
  logic [Y_W-1:0] cpu_y;
  logic [B_W-1:0] cpu_bright;
  logic           cpu_ready;
  logic           cpu_done;

  logic           tst_valid;
  logic [X_W-1:0] tst_x;
  logic [Y_W-1:0] tst_y;
  logic [B_W-1:0] tst_bright;
  logic           tst_ready;

  modport master (
    output cpu_valid, cpu_x, cpu_y, cpu_bright,
    output tst_valid, tst_x, tst_y, tst_bright,
    input  cpu_ready, cpu_done, tst_ready
  );

  modport slave (
    input  cpu_valid, cpu_x, cpu_y, cpu_bright,
    input  tst_valid, tst_x, tst_y, tst_bright,
    output cpu_ready, cpu_done, tst_ready
  );

endinterface

// File: rtl/crt_arb_rr2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie
// goes to whichever requester did not win last.
module crt_arb_rr2
  import crt_arb_pkg::*;
(
  input  logic   cpu_valid,
  input  logic   tst_valid,
  input  owner_e last_owner,
  output logic   grant,
  output owner_e owner
);

  always_comb begin
    // NOTE: defaults first, so no path through the block leaves an output unassigned (no latch).
    grant = cpu_valid | tst_valid;
    owner = OWNER_CPU;
    if (cpu_valid && tst_valid) begin
      owner = (last_owner == OWNER_CPU) ? OWNER_TST : OWNER_CPU;
    end else if (tst_valid) begin
      owner = OWNER_TST;
    end
  end

endmodule

// File: rtl/crt_point_arbiter.sv
// Shares the pdp1_vga_crt point-plot input between the CPU and test requesters,
// pacing strobes GAP cycles apart. Optional per-frame statistics: CRT_ARB_STATS_EN.
module crt_point_arbiter
  import crt_arb_pkg::*;
#(
  parameter int unsigned GAP = 4
) (
  input  logic                  clk_pixel,
  input  logic                  rst_pixel_n,
  input  logic                  arb_enable,
  input  logic                  frame_start,
  crt_point_arbiter_if.slave    req,
  output logic [X_W-1:0]        pixel_x_o,
  output logic [Y_W-1:0]        pixel_y_o,
  output logic [B_W-1:0]        pixel_brightness_o,
  output logic                  pixel_available_o,
  output logic                  owner_cpu_o,
  output logic [15:0]           points_per_frame
);

  // EMIT takes one cycle, so HOLD covers the remaining GAP-2 cycles.
  localparam logic [7:0] GAP_LOAD = 8'(GAP - 2);

  state_e     state;
  logic [7:0] gap_cnt;
  owner_e     last_owner;
  owner_e     owner_q;
  owner_e     win_owner;
  logic       win_grant;
  logic       accept;
  logic       strobe_q;
  logic       cpu_done_q;
  point_t     point_q;
  point_t     cpu_pt;
  point_t     tst_pt;

  crt_arb_rr2 u_rr2 (
    .cpu_valid  (req.cpu_valid),
    .tst_valid  (req.tst_valid),
    .last_owner (last_owner),
    .grant      (win_grant),
    .owner      (win_owner)
  );

  assign cpu_pt = '{x: req.cpu_x, y: req.cpu_y, bright: req.cpu_bright};
  assign tst_pt = '{x: req.tst_x, y: req.tst_y, bright: req.tst_bright};

  // Readies are a same-cycle function of the grant; only IDLE can accept.
  assign accept        = (state == IDLE) && arb_enable && win_grant;
  assign req.cpu_ready = accept && (win_owner == OWNER_CPU);
  assign req.tst_ready = accept && (win_owner == OWNER_TST);
  assign req.cpu_done  = cpu_done_q;

  assign pixel_x_o          = point_q.x;
  assign pixel_y_o          = point_q.y;
  assign pixel_brightness_o = point_q.bright;
  assign pixel_available_o  = strobe_q;
  assign owner_cpu_o        = (owner_q == OWNER_CPU);

  always_ff @(posedge clk_pixel) begin
    if (!rst_pixel_n) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      last_owner <= OWNER_TST;
      owner_q    <= OWNER_TST;
      point_q    <= '0;
      strobe_q   <= 1'b0;
      cpu_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees the pre-edge state and values.
      strobe_q   <= 1'b0;
      cpu_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            point_q    <= (win_owner == OWNER_CPU) ? cpu_pt : tst_pt;
            owner_q    <= win_owner;
            last_owner <= win_owner;
            strobe_q   <= 1'b1;
            cpu_done_q <= (win_owner == OWNER_CPU);
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (GAP == 2) begin
            state <= IDLE;
          end else begin
            gap_cnt <= GAP_LOAD;
            state   <= HOLD;
          end
        end
        HOLD: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt == 8'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CRT_ARB_STATS_EN
  logic [15:0] stat_cnt;
  logic        emit_now;

  assign emit_now = (state == EMIT);

  // A point emitted alongside frame_start belongs to the frame that is starting.
  always_ff @(posedge clk_pixel) begin
    if (!rst_pixel_n) begin
      stat_cnt         <= '0;
      points_per_frame <= '0;
    end else if (frame_start) begin
      points_per_frame <= stat_cnt;
      stat_cnt         <= emit_now ? 16'd1 : 16'd0;
    end else if (emit_now && (stat_cnt != 16'hFFFF)) begin
      stat_cnt <= stat_cnt + 16'd1;
    end
  end
`else
  logic unused_frame_start;

  assign unused_frame_start = frame_start;
  assign points_per_frame   = '0;
`endif

endmodule

// File: doc/crt_point_arbiter.md
# crt_point_arbiter

Sequences and shares the single point-plot input of the `pdp1_vga_crt` phosphor display between two requesters. Requester A is the CPU display (`dpy`) path; requester B is the test/overlay pattern generator. The block accepts points over valid/ready handshakes and arbitrates round-robin. It paces emission so the CRT sees at most one `pixel_available` strobe every `GAP` cycles, and returns a completion pulse to the CPU path. It lives in the `clk_pixel` domain, between the point sources and `pdp1_vga_crt`.

## Interface
- `GAP`, default 4: minimum cycles between successive accepts. Legal range 2..255.
- `clk_pixel`  in  1  pixel clock; all logic runs on its rising edge.
- `rst_pixel_n`  in  1  reset, synchronous, active-low.
- `arb_enable`  in  1  when low, no new point is accepted; an in-flight point still completes.
- `cpu_valid`  in  1  CPU point request.
- `cpu_x`, `cpu_y`  in  10 each  CPU point coordinates.
- `cpu_bright`  in  3  CPU point brightness.
- `cpu_ready`  out  1  the CPU point is accepted this cycle.
- `cpu_done`  out  1  one-cycle pulse when the CPU point reaches the CRT.
- `tst_valid`, `tst_x`, `tst_y`, `tst_bright`, `tst_ready`  same widths and meanings as the CPU signals, for requester B.
- `frame_start`  in  1  one-cycle pulse at the start of each video frame.
- `pixel_x_o`, `pixel_y_o`  out  10 each  point coordinates to the CRT.
- `pixel_brightness_o`  out  3  point brightness to the CRT.
- `pixel_available_o`  out  1  plot strobe to the CRT.
- `owner_cpu_o`  out  1  1 if the current or last emitted point came from the CPU.
- `points_per_frame`  out  16  number of points emitted in the previous frame.

## Operation
- **States:**
  - `IDLE`: accepting.
  - `EMIT`: drive the strobe.
  - `HOLD`: pacing gap.
- **IDLE:**
  - With `arb_enable=1`, the winner's ready is asserted combinationally.
  - When valid&ready is true, capture x/y/brightness and the owner, then go to `EMIT`.
  - If neither requester is valid, or `arb_enable=0`, both readies are 0 and the state stays `IDLE`.
- **Arbitration:**
  - If only one requester is valid, it wins.
  - If both are valid, the requester that did not win last wins.
  - `last_owner` resets to TST, so the CPU wins the first tie.
  - `last_owner` updates only on an accept.
- **EMIT** (exactly one cycle):
  - `pixel_available_o=1`.
  - `cpu_done=1` if the owner is CPU.
  - Load the gap counter with `GAP-2`, then go to `HOLD`. If `GAP=2`, go directly to `IDLE`.
- **HOLD:**
  - Decrement the counter each cycle.
  - At 0, go to `IDLE`.
  - Readies are 0 throughout.
- **Outputs:**
  - `pixel_x_o`, `pixel_y_o` and `pixel_brightness_o` hold the last captured point until the next accept.
  - `owner_cpu_o` follows the captured owner.
- **Requester rules:**
  - A requester holds valid and its data stable until ready.
  - Dropping valid before ready is legal; the point is simply not taken.
- **Reset (including mid-EMIT/HOLD):**
  - State returns to `IDLE` and any pending point is discarded; `cpu_done` is not issued for it.
  - All outputs go to 0.
  - `last_owner` returns to TST.
  - The statistics counter clears.

## Timing
- Accept at cycle T (valid&ready high).
- `pixel_available_o` and `cpu_done` are high in cycle T+1 only.
- Data outputs are valid from T+1.
- The earliest next accept is T+`GAP`.
- Maximum throughput is one point per `GAP` cycles.
- `arb_enable` falling in the same cycle as a valid request blocks that accept.
- `frame_start` coinciding with an EMIT: the emitted point counts toward the new frame.

## Configuration
- **`CRT_ARB_STATS_EN` defined:**
  - A 16-bit counter increments on each EMIT and saturates at 0xFFFF.
  - On `frame_start`, `points_per_frame` takes the counter value and the counter clears. If an EMIT occurs in the same cycle, the counter loads 1 instead of clearing.
- **`CRT_ARB_STATS_EN` undefined:**
  - No counter.
  - `points_per_frame` is constant 0.
  - `frame_start` is ignored.

## Structure
- Package `crt_arb_pkg`:
  - State encoding (`IDLE`, `EMIT`, `HOLD`).
  - Owner constants `OWNER_CPU=1`, `OWNER_TST=0`.
  - Point width constants: X/Y = 10, brightness = 3.
  - Point struct typedef.
- Sub-module `crt_arb_rr2`: a combinational two-way round-robin picker. Inputs are two valids and `last_owner`; outputs are grant and owner.

## Test plan
- **CPU single point:** `cpu_valid=1` with (512, 300, 7) at T; `tst_valid=0`, `GAP=4` → `cpu_ready` high at T; `pixel_available_o`/`cpu_done` high at T+1 with outputs 512/300/7; `cpu_ready` low through T+3.
- **Round-robin:** both valid continuously after reset → accepts at T, T+4, T+8, T+12; owners CPU, TST, CPU, TST; `cpu_done` pulses at T+1 and T+9 only.
- **Enable gating:** `arb_enable=0` with both valid for 20 cycles → no ready, no strobe. Raise it → accept in the same cycle, CPU wins.
- **Reset mid-HOLD:** assert `rst_pixel_n=0` at T+2 after an accept → all outputs 0 next cycle. After release, the CPU wins a tie; no `cpu_done` appears for the aborted point.
- **Stats (macro on):** 37 accepts, then `frame_start` → `points_per_frame=37`. A `frame_start` coinciding with an EMIT → the next report includes that point.
- **GAP=2 boundary:** continuous `tst_valid` → accepts every 2 cycles; the strobe is never high on two consecutive cycles.
